// File: rtl/tdm_demux_1_4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1_4
//
// Time-division 1-to-4 demultiplexer for the receive end of a TDM link.
// Each accepted beat of the serial slot stream is steered into one of four
// per-channel hold registers. A two-state FSM (IDLE / RUN) and a 2-bit slot
// counter track the position of the beat inside the frame. A pulse marks
// frame completion, and another pulse marks framing violations.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (assert async, release sync)
//   in_data    in   WIDTH  slot payload
//   in_valid   in   in_data is valid this cycle
//   in_sof     in   start of frame (slot 0), qualified by in_valid
//   out_data   out  4*WIDTH  hold registers, channel k at [k*WIDTH +: WIDTH]
//   out_valid  out  4  one-cycle write pulse per channel
//   slot       out  2  next expected slot index
//   frame_done out  one-cycle pulse after slot 3 is captured
//   sync_err   out  one-cycle pulse on a framing violation
//
// Configuration macro: TDM_DEMUX_FRAME_LATCH_EN
//   Defined   : slots 0..2 collect in a shadow register. All four channels of
//               out_data update together when frame_done pulses, and
//               out_valid shows 4'b1111 in that same cycle. An aborted frame
//               never reaches out_data.
//   Undefined : each slot write updates its channel of out_data directly.
// -----------------------------------------------------------------------------
module tdm_demux_1_4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    output logic [1:0]           slot,
    output logic                 frame_done,
    output logic                 sync_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_slot;
    logic [1:0]           w_slot_next;
    logic                 w_wr_en;
    logic [1:0]           w_wr_ch;
    logic                 w_done_next;
    logic                 w_err_next;

    logic [4*WIDTH-1:0]   r_data;
    logic [3:0]           r_valid;
    logic                 r_done;
    logic                 r_err;

    // ------------------------------------------------------------------
    // FSM state and slot counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_slot  <= 2'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_slot  <= w_slot_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state, write steering and pulse generation
    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        w_wr_en      = 1'b0;
        w_wr_ch      = 2'd0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;

        if (in_valid) begin
            case (r_state)
                IDLE: begin
                    if (in_sof) begin
                        w_wr_en      = 1'b1;
                        w_wr_ch      = 2'd0;
                        w_slot_next  = 2'd1;
                        w_state_next = RUN;
                    end else begin
                        // A beat without a frame start has nowhere to go.
                        w_err_next   = 1'b1;
                    end
                end
                RUN: begin
                    if (in_sof) begin
                        // Early SOF: abandon the partial frame and restart
                        // at slot 0 with this beat. No frame_done.
                        w_err_next   = 1'b1;
                        w_wr_en      = 1'b1;
                        w_wr_ch      = 2'd0;
                        w_slot_next  = 2'd1;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_wr_ch      = r_slot;
                        if (r_slot == 2'd3) begin
                            w_done_next  = 1'b1;
                            w_slot_next  = 2'd0;
                            w_state_next = IDLE;
                        end else begin
                            w_slot_next  = r_slot + 2'd1;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_slot_next  = 2'd0;
                end
            endcase
        end
    end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    // ------------------------------------------------------------------
    // Frame-latched output. Slot 3 is never stored in the shadow register:
    // it arrives in the same beat that publishes the frame, so it goes
    // straight to out_data.
    // ------------------------------------------------------------------
    logic [3*WIDTH-1:0] r_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_wr_en && (w_wr_ch == 2'(k))) begin
                    r_shadow[k*WIDTH +: WIDTH] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 4'b0000;
        end else begin
            r_valid <= w_done_next ? 4'b1111 : 4'b0000;
            if (w_done_next) begin
                r_data <= {in_data, r_shadow};
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Per-slot output: each write lands directly in its channel.
    // ------------------------------------------------------------------
    logic [3:0] w_wr_onehot;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
            assign w_wr_onehot[gi] = w_wr_en && (w_wr_ch == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 4'b0000;
        end else begin
            r_valid <= w_wr_onehot;
            for (int k = 0; k < 4; k++) begin
                if (w_wr_onehot[k]) begin
                    r_data[k*WIDTH +: WIDTH] <= in_data;
                end
            end
        end
    end
`endif

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign slot       = r_slot;
    assign frame_done = r_done;
    assign sync_err   = r_err;

endmodule
